mp_div: RTL and testbench
=========================

Name: mp_div

Overview:
- Iterative mixed-precision divider: the inverse operation of the team's mp_mult. Same operand conventions: 16-bit operands, data_type_i selects signed INT16 or IEEE-754 FP16.
- Start/busy/valid handshake; one radix-2 quotient bit per cycle; fixed latency independent of mode and operand values.
- Sits beside mp_mult in the pre-process datapath for normalisation and scaling.

Parameters:
- FP_QNAN, 16'h7E00, canonical FP16 NaN returned for invalid operations.
- INT_DZ_QUOT, 16'hFFFF, INT16 quotient returned on divide-by-zero.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request. Accepted on a rising edge when busy_o=0.
- data_type_i  in  1  mode: 0=INT16 signed, 1=FP16. Captured at accept.
- opa_i  in  16  dividend. Captured at accept.
- opb_i  in  16  divisor. Captured at accept.
- busy_o  out  1  high while a division is in flight.
- valid_o  out  1  one-cycle pulse; results valid.
- quot_o  out  16  quotient (INT16 or FP16).
- rem_o  out  16  INT16 remainder; 0 in FP mode.
- dz_o  out  1  divide-by-zero flag. Valid with valid_o and held until the next result.
- inv_o  out  1  FP invalid flag (NaN input, 0/0, inf/inf); 0 in INT mode. Held like dz_o.

Behaviour:
- States: IDLE, ITER, POST, DONE.
- Reset (asynchronous): state=IDLE. busy_o, valid_o, quot_o, rem_o, dz_o and inv_o all 0. All internal registers cleared.
- Reset asserted mid-operation aborts the division; no valid_o follows.
- Accept: start_i=1 in IDLE or DONE on edge E0.
  - Operands and mode are latched; state goes to ITER; busy_o=1 from E0.
  - start_i while busy_o=1 is ignored; no queueing.
- ITER: exactly 16 edges (E1..E16) in both modes.
  - INT uses all 16 iterations.
  - FP uses the first 12 iterations on the 11-bit significands. The remaining iterations idle so latency stays fixed.
  - Special cases also run the full count.
- POST: E17 performs sign, rounding, exponent fix-up and special-case select.
  - Next state DONE, with valid_o=1 for exactly one cycle and busy_o=0.
  - Latency: valid_o is high in the cycle after E17, i.e. 17 edges after accept.
- DONE: with no start, the next edge goes to IDLE. With start_i=1, the block accepts back-to-back.
- quot_o, rem_o, dz_o and inv_o hold their last values until the next POST.
- INT16 mode:
  - Quotient truncates toward zero; remainder takes the dividend's sign; a = q*b + r.
  - Divisor 0: quot=INT_DZ_QUOT, rem=opa_i, dz_o=1.
  - 0x8000 / 0xFFFF: quot=0x8000, rem=0x0000, no flag.
- FP16 mode:
  - Sign = sa XOR sb.
  - Subnormal inputs are flushed to zero; subnormal results are flushed to signed zero.
  - Exponent = ea - eb + 15, minus 1 if the significand quotient is < 1 (then shift left 1).
  - Rounding is toward zero (truncate).
  - Exponent >= 31: result is signed max finite 0x7BFF / 0xFBFF.
  - Exponent <= 0: result is signed zero.
  - Special cases, in priority order:
    - NaN input, 0/0 or inf/inf: quot=FP_QNAN, inv_o=1.
    - Finite nonzero / 0: signed inf, dz_o=1.
    - inf / finite: signed inf.
    - Finite / inf, or 0 / finite nonzero: signed zero.

Test Plan:
- INT 0x0007/0x0002 -> quot=0x0003, rem=0x0001, dz_o=0. valid_o exactly 17 edges after accept, busy_o high for E0..E17.
- INT 0xFFF9 (-7) / 0x0002 -> quot=0xFFFD, rem=0xFFFF. INT 0x8000/0xFFFF -> quot=0x8000, rem=0x0000.
- INT 0x0005/0x0000 -> quot=0xFFFF, rem=0x0005, dz_o=1. Next division 0x0006/0x0003 -> quot=0x0002, dz_o=0.
- FP 0x4000/0x3C00 -> 0x4000; 0x3C00/0x4000 -> 0x3800; 0x3C00/0x4200 -> 0x3555; 0xC400/0x4000 -> 0xC000; 0x7BFF/0x1400 -> 0x7BFF (overflow saturates). rem_o=0 throughout.
- FP specials: 0x3C00/0x0000 -> 0x7C00, dz_o=1; 0x0000/0x0000 -> 0x7E00, inv_o=1; 0x7C00/0x3C00 -> 0x7C00; 0x3C00/0x7C00 -> 0x0000; 0x7E01/0x3C00 -> 0x7E00, inv_o=1.
- Control:
  - start_i pulsed at E5 of a busy division is ignored; the result is unchanged.
  - start_i held in the DONE cycle is accepted back-to-back.
  - rst_n_i low at E8 -> all outputs 0 immediately, no valid_o; a fresh start afterwards gives the correct result.

Source files
------------

// File: rtl/mp_div.sv
// Iterative mixed-precision divider for signed INT16 and FP16 operands.
// One radix-2 quotient bit per cycle, with a fixed 17-edge latency from accept to result.
//
// state | meaning
// IDLE  | waiting for start_i
// ITER  | 16 restoring-division steps (FP uses the first 12, the rest idle)
// POST  | sign, exponent fix-up, rounding and special-case select
// DONE  | valid_o high for one cycle; start_i accepted back-to-back
module mp_div #(
  parameter logic [15:0] FP_QNAN     = 16'h7E00,
  parameter logic [15:0] INT_DZ_QUOT = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        data_type_i,
  input  logic [15:0] opa_i,
  input  logic [15:0] opb_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [15:0] quot_o,
  output logic [15:0] rem_o,
  output logic        dz_o,
  output logic        inv_o
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_POST, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_mode;
  logic [15:0] r_opa, r_opb;
  logic [3:0]  r_cnt;
  logic [15:0] r_q;
  logic [16:0] r_rem;
  logic [15:0] r_dvd;
  logic [15:0] r_dvs;
  logic [15:0] r_quot, r_rem_out;
  logic        r_dz, r_inv;

  logic        w_accept;
  logic [15:0] w_abs_a, w_abs_b;
  logic [16:0] w_trial, w_sub, w_rem_nxt;
  logic        w_ge, w_step;

  assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_abs_a  = opa_i[15] ? (16'd0 - opa_i) : opa_i;
  assign w_abs_b  = opb_i[15] ? (16'd0 - opb_i) : opb_i;

  // INT shifts the next dividend bit in before the compare; FP compares first and shifts after.
  assign w_trial   = r_mode ? r_rem : {r_rem[15:0], r_dvd[15]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs});
  assign w_sub     = w_ge ? (w_trial - {1'b0, r_dvs}) : w_trial;
  assign w_rem_nxt = r_mode ? {w_sub[15:0], 1'b0} : w_sub;
  assign w_step    = !r_mode || (r_cnt >= 4'd4);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = S_ITER;
      S_ITER: if (r_cnt == 4'd0) w_next = S_POST;
      S_POST: w_next = S_DONE;
      S_DONE: w_next = start_i ? S_ITER : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mode <= 1'b0;
      r_opa  <= '0;
      r_opb  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
    end else if (w_accept) begin
      r_mode <= data_type_i;
      r_opa  <= opa_i;
      r_opb  <= opb_i;
      r_cnt  <= 4'd15;
      r_q    <= '0;
      if (data_type_i) begin
        r_rem <= {6'd0, 1'b1, opa_i[9:0]};
        r_dvd <= '0;
        r_dvs <= {5'd0, 1'b1, opb_i[9:0]};
      end else begin
        r_rem <= '0;
        r_dvd <= w_abs_a;
        r_dvs <= w_abs_b;
      end
    end else if (r_state == S_ITER) begin
      r_cnt <= r_cnt - 4'd1;
      if (w_step) begin
        r_q   <= {r_q[14:0], w_ge};
        r_rem <= w_rem_nxt;
        r_dvd <= {r_dvd[14:0], 1'b0};
      end
    end
  end

  logic [4:0]  w_ea, w_eb;
  logic        w_sq, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [6:0]  w_exp;
  logic [9:0]  w_frac;
  logic [15:0] w_res_quot, w_res_rem;
  logic        w_res_dz, w_res_inv;

  assign w_ea     = r_opa[14:10];
  assign w_eb     = r_opb[14:10];
  assign w_sq     = r_opa[15] ^ r_opb[15];
  assign w_a_zero = (w_ea == 5'd0);
  assign w_b_zero = (w_eb == 5'd0);
  assign w_a_inf  = (w_ea == 5'd31) && (r_opa[9:0] == 10'd0);
  assign w_b_inf  = (w_eb == 5'd31) && (r_opb[9:0] == 10'd0);
  assign w_a_nan  = (w_ea == 5'd31) && (r_opa[9:0] != 10'd0);
  assign w_b_nan  = (w_eb == 5'd31) && (r_opb[9:0] != 10'd0);
  // Two's-complement in 7 bits: bit 6 set means the biased exponent went negative.
  assign w_exp    = {2'b00, w_ea} - {2'b00, w_eb} + 7'd15 - {6'd0, ~r_q[11]};
  assign w_frac   = r_q[11] ? r_q[10:1] : r_q[9:0];

  always_comb begin
    w_res_quot = '0;
    w_res_rem  = '0;
    w_res_dz   = 1'b0;
    w_res_inv  = 1'b0;
    if (!r_mode) begin
      if (r_opb == 16'd0) begin
        w_res_quot = INT_DZ_QUOT;
        w_res_rem  = r_opa;
        w_res_dz   = 1'b1;
      end else begin
        w_res_quot = (r_opa[15] ^ r_opb[15]) ? (16'd0 - r_q) : r_q;
        w_res_rem  = r_opa[15] ? (16'd0 - r_rem[15:0]) : r_rem[15:0];
      end
    end else if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_res_quot = FP_QNAN;
      w_res_inv  = 1'b1;
    end else if (!w_a_inf && w_b_zero) begin
      w_res_quot = {w_sq, 15'h7C00};
      w_res_dz   = 1'b1;
    end else if (w_a_inf) begin
      w_res_quot = {w_sq, 15'h7C00};
    end else if (w_b_inf || w_a_zero) begin
      w_res_quot = {w_sq, 15'd0};
    end else if (w_exp[6] || (w_exp == 7'd0)) begin
      w_res_quot = {w_sq, 15'd0};
    end else if (w_exp >= 7'd31) begin
      w_res_quot = {w_sq, 15'h7BFF};
    end else begin
      w_res_quot = {w_sq, w_exp[4:0], w_frac};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dz      <= 1'b0;
      r_inv     <= 1'b0;
    end else if (r_state == S_POST) begin
      r_quot    <= w_res_quot;
      r_rem_out <= w_res_rem;
      r_dz      <= w_res_dz;
      r_inv     <= w_res_inv;
    end
  end

  assign busy_o  = (r_state == S_ITER) || (r_state == S_POST);
  assign valid_o = (r_state == S_DONE);
  assign quot_o  = r_quot;
  assign rem_o   = r_rem_out;
  assign dz_o    = r_dz;
  assign inv_o   = r_inv;

endmodule

// File: tb/tb_mp_div.sv
// Directed bench for mp_div: INT16/FP16 quotients, special cases, latency and handshake control.
module tb_mp_div;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        data_type_i = 1'b0;
  logic [15:0] opa_i = '0;
  logic [15:0] opb_i = '0;
  logic        busy_o, valid_o, dz_o, inv_o;
  logic [15:0] quot_o, rem_o;

  int n_checks = 0;
  int n_fail   = 0;

  mp_div dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .data_type_i(data_type_i),
    .opa_i(opa_i), .opb_i(opb_i), .busy_o(busy_o), .valid_o(valid_o),
    .quot_o(quot_o), .rem_o(rem_o), .dz_o(dz_o), .inv_o(inv_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a request so it is sampled on the next rising edge, then drops start_i.
  task automatic start_op(input logic mode, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk_i);
    start_i = 1'b1; data_type_i = mode; opa_i = a; opb_i = b;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (valid_o !== 1'b1 && n < 40) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk_i);
      #1 n++;
    end
  endtask

  task automatic run_div(input string tag, input logic mode, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz, input logic einv);
    int n;
    bit bok;
    start_op(mode, a, b);
    wait_valid(n, bok);
    check({tag, " latency"}, 16'(n), 16'd17);
    check({tag, " busy_in_flight"}, {15'd0, bok}, 16'd1);
    check({tag, " busy_at_valid"}, {15'd0, busy_o}, 16'd0);
    check({tag, " quot"}, quot_o, eq);
    check({tag, " rem"}, rem_o, er);
    check({tag, " dz"}, {15'd0, dz_o}, {15'd0, edz});
    check({tag, " inv"}, {15'd0, inv_o}, {15'd0, einv});
  endtask

  initial begin
    int n;
    bit bok;
    int vcount;

    #1;
    check("rst busy",  {15'd0, busy_o},  16'd0);
    check("rst valid", {15'd0, valid_o}, 16'd0);
    check("rst quot",  quot_o, 16'd0);
    check("rst rem",   rem_o,  16'd0);
    check("rst dz",    {15'd0, dz_o},  16'd0);
    check("rst inv",   {15'd0, inv_o}, 16'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    run_div("int 7/2", 1'b0, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    check("valid one cycle", {15'd0, valid_o}, 16'd0);
    run_div("int -7/2", 1'b0, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    run_div("int min/-1", 1'b0, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b0);
    run_div("int 5/0", 1'b0, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1'b0);
    repeat (3) @(posedge clk_i); #1;
    check("dz held", {15'd0, dz_o}, 16'd1);
    run_div("int 6/3", 1'b0, 16'h0006, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1'b0);
    run_div("int 100/-7", 1'b0, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0);

    run_div("fp 2/1",      1'b1, 16'h4000, 16'h3C00, 16'h4000, 16'h0000, 1'b0, 1'b0);
    run_div("fp 1/2",      1'b1, 16'h3C00, 16'h4000, 16'h3800, 16'h0000, 1'b0, 1'b0);
    run_div("fp 1/3",      1'b1, 16'h3C00, 16'h4200, 16'h3555, 16'h0000, 1'b0, 1'b0);
    run_div("fp -4/2",     1'b1, 16'hC400, 16'h4000, 16'hC000, 16'h0000, 1'b0, 1'b0);
    run_div("fp ovf",      1'b1, 16'h7BFF, 16'h1400, 16'h7BFF, 16'h0000, 1'b0, 1'b0);
    run_div("fp 1/0",      1'b1, 16'h3C00, 16'h0000, 16'h7C00, 16'h0000, 1'b1, 1'b0);
    run_div("fp 0/0",      1'b1, 16'h0000, 16'h0000, 16'h7E00, 16'h0000, 1'b0, 1'b1);
    run_div("fp inf/1",    1'b1, 16'h7C00, 16'h3C00, 16'h7C00, 16'h0000, 1'b0, 1'b0);
    run_div("fp 1/inf",    1'b1, 16'h3C00, 16'h7C00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_div("fp nan/1",    1'b1, 16'h7E01, 16'h3C00, 16'h7E00, 16'h0000, 1'b0, 1'b1);
    run_div("fp udf",      1'b1, 16'h0400, 16'h7800, 16'h8000 & 16'h0000, 16'h0000, 1'b0, 1'b0);

    // A start pulse while busy must not disturb the division in flight.
    @(posedge clk_i); @(posedge clk_i); #1;
    start_op(1'b0, 16'h0007, 16'h0002);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1; data_type_i = 1'b1; opa_i = 16'h0009; opb_i = 16'h0003;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_valid(n, bok);
    check("poke latency", 16'(n), 16'd12);
    check("poke quot", quot_o, 16'h0003);
    check("poke rem", rem_o, 16'h0001);
    @(posedge clk_i); #1;
    check("poke no requeue busy", {15'd0, busy_o}, 16'd0);

    // Reset mid-operation aborts with no valid.
    start_op(1'b0, 16'h0064, 16'h0007);
    repeat (7) @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    check("abort busy",  {15'd0, busy_o},  16'd0);
    check("abort valid", {15'd0, valid_o}, 16'd0);
    check("abort quot",  quot_o, 16'd0);
    check("abort rem",   rem_o,  16'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    vcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk_i); #1;
      if (valid_o === 1'b1) vcount++;
    end
    check("abort no valid", 16'(vcount), 16'd0);
    run_div("post-rst 100/7", 1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
